load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/ld_pkg.sv | 27 ++
 rtl/ld_ext.sv | 32 +++
 rtl/load_align_unit.sv | 117 +++++++++++
 tb/tb_load_align_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_pkg.sv
// Shared load-type encodings, FSM states and the alignment predicate
// for load_align_unit.
package ld_pkg;

   localparam logic [2:0] LT_LW  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LHU = 3'b010;
   localparam logic [2:0] LT_LB  = 3'b011;
   localparam logic [2:0] LT_LBU = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_READ = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Codes 101-111 behave as lw, so they need word alignment too.
   function automatic logic misaligned(input logic [2:0] lt,
                                       input logic [1:0] a);
      case (lt)
         LT_LH, LT_LHU: misaligned = a[0];
         LT_LB, LT_LBU: misaligned = 1'b0;
         default:       misaligned = (a != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/ld_ext.sv
// Byte/halfword lane select with sign or zero extension.
// Purely combinational; lw passes the word through.
module ld_ext
   import ld_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  ltype,
   output logic [31:0] result
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      case (addr)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = addr[1] ? word[31:16] : word[15:0];
      case (ltype)
         LT_LB:   result = {{24{b[7]}}, b};
         LT_LBU:  result = {24'h0, b};
         LT_LH:   result = {{16{h[15]}}, h};
         LT_LHU:  result = {16'h0, h};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: bus read, wait timeout, lane align.
// Define LOAD_ALIGN_CHECK_EN to trap misaligned loads as adel.
module load_align_unit
   import ld_pkg::*;
#(
   parameter int WAIT_MAX = 15
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [2:0]  ltype,
   output logic        bus_rd,
   output logic [31:0] bus_addr,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic [31:0] rdata,
   output logic        done,
   output logic        busy,
   output logic        timeout,
   output logic        adel
);

   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT_MAX);

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [31:0]   addr_q;
   logic [2:0]    ltype_q;
   logic [31:0]   ext;
   logic          misal;
   logic          adel_q;
   logic          expire;

`ifdef LOAD_ALIGN_CHECK_EN
   assign misal = misaligned(ltype, addr[1:0]);
`else
   assign misal = 1'b0;
`endif

   ld_ext u_ext (
      .word   (bus_rdata),
      .addr   (addr_q[1:0]),
      .ltype  (ltype_q),
      .result (ext)
   );

   assign expire   = (cnt == WAIT_CNT);
   assign bus_rd   = (state == S_READ);
   assign done     = (state == S_DONE);
   assign busy     = (state != S_IDLE);
   assign bus_addr = {addr_q[31:2], 2'b00};
   assign adel     = adel_q;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (req)
               state_n = misal ? S_DONE : S_READ;
         end
         S_READ: begin
            if (bus_ack || expire)
               state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         ltype_q <= LT_LW;
         rdata   <= '0;
         timeout <= 1'b0;
         adel_q  <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            S_IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  ltype_q <= ltype;
                  cnt     <= '0;
                  if (misal) begin
                     rdata   <= '0;
                     timeout <= 1'b0;
                     adel_q  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               // A late ack still beats the timeout on the last cycle.
               if (bus_ack) begin
                  rdata   <= ext;
                  timeout <= 1'b0;
                  adel_q  <= 1'b0;
               end else if (expire) begin
                  rdata   <= '0;
                  timeout <= 1'b1;
                  adel_q  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit with immediate-assertion checks.
// Works with or without LOAD_ALIGN_CHECK_EN defined.
module tb_load_align_unit;
   import ld_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic [2:0]  ltype;
   logic        bus_rd;
   logic [31:0] bus_addr;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic [31:0] rdata;
   logic        done;
   logic        busy;
   logic        timeout;
   logic        adel;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   int d0;

   load_align_unit #(.WAIT_MAX(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .addr      (addr),
      .ltype     (ltype),
      .bus_rd    (bus_rd),
      .bus_addr  (bus_addr),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .rdata     (rdata),
      .done      (done),
      .busy      (busy),
      .timeout   (timeout),
      .adel      (adel)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (done === 1'b1) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"}, {31'h0, busy}, 32'h0);
      chk({tag, ".done"}, {31'h0, done}, 32'h0);
      chk({tag, ".bus_rd"}, {31'h0, bus_rd}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; addr = '0; ltype = LT_LW;
      bus_rdata = '0; bus_ack = 1'b0;
      step();
      step();
      chk_idle("rst");
      chk("rst.bus_addr", bus_addr, 32'h0);
      chk("rst.rdata", rdata, 32'h0);
      chk("rst.timeout", {31'h0, timeout}, 32'h0);
      chk("rst.adel", {31'h0, adel}, 32'h0);
      rst = 1'b0;
      step();

      // lb at ...3, ack on first READ cycle
      req = 1'b1; addr = 32'h1000_0003; ltype = LT_LB;
      step();
      req = 1'b0;
      chk("lb.bus_rd", {31'h0, bus_rd}, 32'h1);
      chk("lb.bus_addr", bus_addr, 32'h1000_0000);
      chk("lb.busy", {31'h0, busy}, 32'h1);
      bus_ack = 1'b1; bus_rdata = 32'h8011_2233;
      step();
      bus_ack = 1'b0;
      chk("lb.done", {31'h0, done}, 32'h1);
      chk("lb.rdata", rdata, 32'hFFFF_FF80);
      chk("lb.timeout", {31'h0, timeout}, 32'h0);
      step();
      chk_idle("lb.after");
      chk("lb.hold", rdata, 32'hFFFF_FF80);

      // ack in IDLE is ignored
      bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
      step();
      bus_ack = 1'b0;
      chk_idle("idle_ack");
      chk("idle_ack.rdata", rdata, 32'hFFFF_FF80);

      // lhu at ...2, three wait cycles
      req = 1'b1; addr = 32'h2000_0006; ltype = LT_LHU;
      bus_rdata = 32'hDEAD_BEEF;
      step();
      req = 1'b0;
      chk("lhu.bus_addr", bus_addr, 32'h2000_0004);
      step();
      step();
      chk("lhu.wait_rd", {31'h0, bus_rd}, 32'h1);
      chk("lhu.wait_done", {31'h0, done}, 32'h0);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h9ABC_1234;
      step();
      bus_ack = 1'b0;
      chk("lhu.done", {31'h0, done}, 32'h1);
      chk("lhu.rdata", rdata, 32'h0000_9ABC);
      step();

      // lh sign-extend, both halves
      req = 1'b1; addr = 32'h0000_0002; ltype = LT_LH;
      step();
      req = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h8001_7FFF;
      step();
      bus_ack = 1'b0;
      chk("lh_hi.rdata", rdata, 32'hFFFF_8001);
      step();
      req = 1'b1; addr = 32'h0000_0000; ltype = LT_LH;
      step();
      req = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h8001_7FFF;
      step();
      bus_ack = 1'b0;
      chk("lh_lo.rdata", rdata, 32'h0000_7FFF);
      step();

      // lw with no ack -> timeout after 16 READ cycles
      req = 1'b1; addr = 32'h3000_0008; ltype = LT_LW;
      d0 = done_cnt;
      step();
      req = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("to.last_read_rd", {31'h0, bus_rd}, 32'h1);
      chk("to.last_read_done", {31'h0, done}, 32'h0);
      step();
      chk("to.done", {31'h0, done}, 32'h1);
      chk("to.timeout", {31'h0, timeout}, 32'h1);
      chk("to.rdata", rdata, 32'h0);
      step();
      chk_idle("to.after");
      chk("to.hold", {31'h0, timeout}, 32'h1);
      chk("to.pulses", done_cnt - d0, 1);

      // req held high, ack on the WAIT_MAX cycle
      req = 1'b1; addr = 32'h4000_0000; ltype = LT_LW;
      d0 = done_cnt;
      step();
      for (int i = 0; i < 15; i++) step();
      bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      step();
      bus_ack = 1'b0;
      chk("wm.done", {31'h0, done}, 32'h1);
      chk("wm.timeout", {31'h0, timeout}, 32'h0);
      chk("wm.rdata", rdata, 32'hCAFE_F00D);
      step();
      chk("wm.idle_busy", {31'h0, busy}, 32'h0);
      chk("wm.pulses1", done_cnt - d0, 1);
      step();
      req = 1'b0;
      chk("wm.reaccept", {31'h0, bus_rd}, 32'h1);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_0001;
      step();
      bus_ack = 1'b0;
      chk("wm.rdata2", rdata, 32'h0BAD_0001);
      step();
      chk("wm.pulses2", done_cnt - d0, 2);

      // misaligned lw at ...1
      req = 1'b1; addr = 32'h5000_0001; ltype = LT_LW;
      step();
      req = 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
      chk("adel.bus_rd", {31'h0, bus_rd}, 32'h0);
      chk("adel.done", {31'h0, done}, 32'h1);
      chk("adel.adel", {31'h0, adel}, 32'h1);
      chk("adel.rdata", rdata, 32'h0);
`else
      chk("mis.bus_rd", {31'h0, bus_rd}, 32'h1);
      chk("mis.bus_addr", bus_addr, 32'h5000_0000);
      bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
      step();
      bus_ack = 1'b0;
      chk("mis.done", {31'h0, done}, 32'h1);
      chk("mis.adel", {31'h0, adel}, 32'h0);
      chk("mis.rdata", rdata, 32'h1122_3344);
`endif
      step();
      chk_idle("mis.after");

      // reset mid-READ, then a stray ack
      req = 1'b1; addr = 32'h6000_0001; ltype = LT_LB;
      d0 = done_cnt;
      step();
      req = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("rr.rst");
      chk("rr.bus_addr", bus_addr, 32'h0);
      chk("rr.rdata", rdata, 32'h0);
      chk("rr.timeout", {31'h0, timeout}, 32'h0);
      chk("rr.adel", {31'h0, adel}, 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
      step();
      bus_ack = 1'b0;
      chk_idle("rr.stray");
      chk("rr.no_done", done_cnt - d0, 0);

      // next req accepted normally: lbu at ...1
      req = 1'b1; addr = 32'h6000_0001; ltype = LT_LBU;
      step();
      req = 1'b0;
      chk("rr.bus_rd", {31'h0, bus_rd}, 32'h1);
      bus_ack = 1'b1; bus_rdata = 32'h0000_AB00;
      step();
      bus_ack = 1'b0;
      chk("rr.done", {31'h0, done}, 32'h1);
      chk("rr.lbu", rdata, 32'h0000_00AB);
      step();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
